uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  UART receiver for 8N1 serial frames, the receive side of the board UART link.
//  It shares the free-running 16x oversampling b_tick generator with the transmitter.
//  It synchronises the asynchronous rx line, detects and validates the start bit,
//  and samples each data bit at mid-bit.
//  It presents the received byte with a one-clock done strobe and a framing-error flag.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, LSB first
//  OVERSAMPLE  16  b_tick pulses per bit period
// PORTS
//  clk        in   1          system clock; all state updates on its rising edge
//  reset      in   1          asynchronous, active-high
//  b_tick     in   1          1-clk strobe at OVERSAMPLE x baud rate
//  rx         in   1          serial input; idles high; asynchronous to clk
//  rx_data    out  DATA_BITS  last received byte; held until the next rx_done
//  rx_done    out  1          1-clk pulse when a frame completes
//  rx_busy    out  1          high while a frame is being received
//  frame_err  out  1          1-clk pulse, coincident with rx_done, when the stop bit samples low
// BEHAVIOUR
//  - Reset values: all outputs 0; state IDLE; tick_cnt, bit_cnt and shift register 0;
//    synchroniser flops set to 1 (idle line).
//  - rx passes through a 2-flop synchroniser; rx_s below means the synchronised value.
//  - All counters advance only in cycles where b_tick=1. Without b_tick, state holds.
//  - IDLE:
//    - b_tick & rx_s==0 -> START with tick_cnt=0. rx_busy=0 in IDLE.
//  - START (half-bit check):
//    - On b_tick with tick_cnt==OVERSAMPLE/2-1 (7):
//      - rx_s==0 -> DATA with tick_cnt=0, bit_cnt=0.
//      - rx_s==1 -> IDLE (glitch rejected); no rx_done, no frame_err.
//    - On any other b_tick, tick_cnt+1.
//  - DATA:
//    - On b_tick with tick_cnt==OVERSAMPLE-1 (15): tick_cnt=0; shift={rx_s, shift[7:1]}.
//      - bit_cnt==DATA_BITS-1 -> STOP.
//      - Otherwise bit_cnt+1.
//    - On any other b_tick, tick_cnt+1.
//  - STOP:
//    - On b_tick with tick_cnt==15:
//      - rx_data<=shift; rx_done=1 for exactly one clk; frame_err=~rx_s (same clk).
//      - -> IDLE with tick_cnt=0.
//    - rx_data updates even on a framing error.
//  - rx_busy=1 in START, DATA and STOP, registered with the state.
//  - Latency: rx_done is registered and asserts in the clk after the b_tick at mid-stop-bit,
//    i.e. about 9.5 bit periods after the falling edge of the start bit.
//  - Counter widths: tick_cnt is 4 bits and bit_cnt is 3 bits; wrap is never reached by design.
//  - A start bit is accepted from IDLE only. A falling edge during STOP is ignored until
//    IDLE is re-entered, at the next b_tick after rx_done.
//  - Break condition (rx held low): each frame completes with frame_err=1 and rx_data=8'h00,
//    then re-arms immediately.
//  - Reset mid-frame: immediate return to IDLE with all outputs 0. The partial byte is
//    discarded and no rx_done is produced.
// STRUCTURE
//  - Shared uart package holds:
//    - state encoding (IDLE=0, START=1, DATA=2, STOP=3), common with the transmitter;
//    - OVERSAMPLE and DATA_BITS defaults.
//  - One sub-module: sync_2ff (2-flop synchroniser, parameterised reset value, here 1).
//  - The remaining logic is a single FSM: a registered state and datapath, plus one
//    combinational next-state block.
// TESTING
//  - Baud period 16 b_ticks. Send 0x55 as 8N1:
//    rx_done pulses once, rx_data=8'h55, frame_err=0, rx_busy drops in the same clk as rx_done.
//  - Back-to-back frames 0xA3 then 0x0F with no idle gap:
//    two rx_done pulses, rx_data=8'hA3 then 8'h0F.
//  - rx low pulse of 4 b_ticks, then high: returns to IDLE, no rx_done, rx_busy high for 8 ticks only.
//  - Frame 0xFF with the stop bit forced low: rx_done=1, frame_err=1 in the same clk, rx_data=8'hFF.
//  - Assert reset during the 4th data bit of 0x3C: all outputs 0 at once.
//    A following clean 0xC3 frame is received correctly.
//  - Random bytes, with rx edges jittered ±3 clk relative to b_tick: all 256 values are
//    received without error.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and transmitter.
// Contents:
//   uart_state_e     frame state encoding (Idle=0, Start=1, Data=2, Stop=3)
//   OVERSAMPLE       b_tick pulses per bit period
//   DATA_BITS        data bits per frame, LSB first
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  // Encoding is shared with the transmitter; do not reorder.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high; both flops load RESET_VAL
//   i_d    asynchronous input
//   o_q    synchronised output (two clk of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver driven by the shared oversampling b_tick strobe.
// The start bit is re-checked at half a bit period, then each data bit and the stop
// bit are sampled at mid-bit.
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   b_tick     1-clk strobe at OVERSAMPLE x baud
//   rx         serial input, idles high, asynchronous to clk
//   rx_data    last received byte, held until the next rx_done
//   rx_done    1-clk pulse when a frame completes
//   rx_busy    high while a frame is in progress
//   frame_err  1-clk pulse with rx_done when the stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DataBits   = uart_pkg::DATA_BITS,
  parameter int unsigned Oversample = uart_pkg::OVERSAMPLE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                b_tick,
  input  logic                rx,
  output logic [DataBits-1:0] rx_data,
  output logic                rx_done,
  output logic                rx_busy,
  output logic                frame_err
);

  localparam int unsigned TickW = $clog2(Oversample);
  localparam int unsigned BitW  = $clog2(DataBits);
  localparam logic [TickW-1:0] TickHalf = TickW'(Oversample / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(Oversample - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataBits - 1);

  logic w_rx_s;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  uart_state_e         r_state, w_state;
  logic [TickW-1:0]    r_tick, w_tick;
  logic [BitW-1:0]     r_bit, w_bit;
  logic [DataBits-1:0] r_shift, w_shift;
  logic [DataBits-1:0] r_data, w_data;
  logic                r_done, w_done;
  logic                r_ferr, w_ferr;
  logic                r_busy, w_busy;

  always_comb begin
    w_state = r_state;
    w_tick  = r_tick;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_data  = r_data;
    w_done  = 1'b0;
    w_ferr  = 1'b0;
    if (b_tick) begin
      unique case (r_state)
        StIdle: begin
          if (!w_rx_s) begin
            w_state = StStart;
            w_tick  = '0;
          end
        end
        StStart: begin
          if (r_tick == TickHalf) begin
            w_tick = '0;
            if (!w_rx_s) begin
              w_state = StData;
              w_bit   = '0;
            end else begin
              // Start bit did not last half a bit: treat as a glitch.
              w_state = StIdle;
            end
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        StData: begin
          if (r_tick == TickLast) begin
            w_tick  = '0;
            w_shift = {w_rx_s, r_shift[DataBits-1:1]};
            if (r_bit == BitLast) begin
              w_state = StStop;
            end else begin
              w_bit = r_bit + 1'b1;
            end
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        StStop: begin
          if (r_tick == TickLast) begin
            w_tick  = '0;
            w_data  = r_shift;
            w_done  = 1'b1;
            w_ferr  = ~w_rx_s;
            w_state = StIdle;
          end else begin
            w_tick = r_tick + 1'b1;
          end
        end
        default: w_state = StIdle;
      endcase
    end
    // Busy is registered alongside the state so it falls with rx_done.
    w_busy = (w_state != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tick  <= w_tick;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_done  <= w_done;
      r_ferr  <= w_ferr;
      r_busy  <= w_busy;
    end
  end

  assign rx_data   = r_data;
  assign rx_done   = r_done;
  assign rx_busy   = r_busy;
  assign frame_err = r_ferr;

endmodule
